// File: rtl/slt_pkg.sv
// Shared types for the bit-serial signed less-than comparator.
package slt_pkg;

   // Controller states: waiting for operands, shifting bits, holding result.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } slt_state_t;

endpackage

// File: rtl/adder_1.sv
// One-bit full adder used as the serial subtract stage.
module adder_1 (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   // Sum and majority carry.
   always_comb begin
      sum   = a ^ b ^ c_in;
      c_out = (a & b) | (a & c_in) | (b & c_in);
   end

endmodule

// File: rtl/slt_serial.sv
// Bit-serial signed a < b: computes a - b one bit per cycle, LSB first,
// and reports sign XOR overflow of the difference.
module slt_serial
   import slt_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   output logic         i_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         o_valid,
   input  logic         o_ready,
   output logic         out
);

   localparam int unsigned CntW = $clog2(N);

   slt_state_t    state_q, state_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic          carry_q, carry_d;
   logic          out_q, out_d;

   logic          b_inv;
   logic          bit_sum;
   logic          bit_cout;
   logic          last_bit;

   assign b_inv    = ~b_q[0];
   assign last_bit = (cnt_q == CntW'(N - 1));

   adder_1 u_adder (
      .a     (a_q[0]),
      .b     (b_inv),
      .c_in  (carry_q),
      .sum   (bit_sum),
      .c_out (bit_cout)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (i_valid) state_d = S_RUN;
         S_RUN:  if (last_bit) state_d = S_DONE;
         S_DONE: if (o_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: capture in idle, shift-and-add while running.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      out_d   = out_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               a_d     = a;
               b_d     = b;
               cnt_d   = '0;
               carry_d = 1'b1;  // +1 completes the two's complement of b
            end
         end
         S_RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = bit_cout;
            if (last_bit) begin
               // Counter parks at N-1 so it never wraps.
               out_d = bit_sum ^ (carry_q ^ bit_cout);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         out_q   <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         out_q   <= out_d;
      end
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      i_ready = (state_q == S_IDLE);
      o_valid = (state_q == S_DONE);
      out     = out_q;
   end

endmodule

// File: tb/tb_slt_serial.sv
// Directed bench for slt_serial: N=32 scenarios plus exhaustive N=4.
module tb_slt_serial;

   logic        clk;
   logic        rst;

   logic        i_valid;
   logic        i_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        o_valid;
   logic        o_ready;
   logic        out;

   logic        i_valid4;
   logic        i_ready4;
   logic [3:0]  a4;
   logic [3:0]  b4;
   logic        o_valid4;
   logic        o_ready4;
   logic        out4;

   int n_tests = 0;
   int n_fail  = 0;

   logic exp_q[$];
   logic exp4_q[$];

   slt_serial #(.N(32)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .a       (a),
      .b       (b),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .out     (out)
   );

   slt_serial #(.N(4)) u_dut4 (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid4),
      .i_ready (i_ready4),
      .a       (a4),
      .b       (b4),
      .o_valid (o_valid4),
      .o_ready (o_ready4),
      .out     (out4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor, N=32: compare on each completed output handshake.
   always @(negedge clk) begin
      if (rst && o_valid && o_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL n32 unexpected result: got out=%0b with no pending expectation", out);
         end else begin
            check("n32 out", {31'd0, out}, {31'd0, exp_q.pop_front()});
         end
      end
   end

   // Scoreboard monitor, N=4.
   always @(negedge clk) begin
      if (rst && o_valid4 && o_ready4) begin
         if (exp4_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL n4 unexpected result: got out=%0b with no pending expectation", out4);
         end else begin
            check("n4 out", {31'd0, out4}, {31'd0, exp4_q.pop_front()});
         end
      end
   end

   // Present one operand pair for a single cycle; caller ensures i_ready.
   task automatic issue(input logic [31:0] va, input logic [31:0] vb);
      a       = va;
      b       = vb;
      i_valid = 1'b1;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   // Count edges until o_valid is seen, bounded.
   task automatic wait_valid(output int edges);
      edges = 0;
      while (edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
         if (o_valid) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL n32 timeout: got no o_valid, expected it within 200 edges");
   endtask

   task automatic run(input logic [31:0] va, input logic [31:0] vb, input logic exp);
      int e;
      exp_q.push_back(exp);
      issue(va, vb);
      wait_valid(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int e;
      int guard;
      rst      = 1'b0;
      i_valid  = 1'b0;
      a        = '0;
      b        = '0;
      o_ready  = 1'b1;
      i_valid4 = 1'b0;
      a4       = '0;
      b4       = '0;
      o_ready4 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      // Post-reset state.
      check("reset i_ready", {31'd0, i_ready}, 32'd1);
      check("reset o_valid", {31'd0, o_valid}, 32'd0);
      check("reset out", {31'd0, out}, 32'd0);

      // -1 < 1, with latency measurement.
      exp_q.push_back(1'b1);
      issue(32'hFFFF_FFFF, 32'd1);
      wait_valid(e);
      check("latency edges", e, 32'd32);
      @(posedge clk);
      #1;
      check("i_ready after done", {31'd0, i_ready}, 32'd1);
      check("o_valid after done", {31'd0, o_valid}, 32'd0);

      // Overflow boundaries and equality.
      run(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
      run(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
      run(32'h0000_0000, 32'h0000_0000, 1'b0);
      run(32'd5, 32'hFFFF_FFFB, 1'b0);
      run(32'hFFFF_FFFB, 32'd5, 1'b1);

      // Result held under backpressure while inputs toggle.
      o_ready = 1'b0;
      exp_q.push_back(1'b0);
      issue(32'h7FFF_FFFF, 32'h8000_0000);
      wait_valid(e);
      for (int i = 0; i < 5; i++) begin
         a       = $urandom;
         b       = $urandom;
         i_valid = ~i_valid;
         @(posedge clk);
         #1;
         check("hold o_valid", {31'd0, o_valid}, 32'd1);
         check("hold out", {31'd0, out}, 32'd0);
      end
      i_valid = 1'b0;
      o_ready = 1'b1;
      @(posedge clk);
      #1;
      check("i_ready after hold", {31'd0, i_ready}, 32'd1);

      // Leave out=1 registered, then reset in the middle of a run.
      run(32'h8000_0000, 32'd0, 1'b1);
      issue(32'hFFFF_FFFF, 32'd1);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midrun reset i_ready", {31'd0, i_ready}, 32'd1);
      check("midrun reset o_valid", {31'd0, o_valid}, 32'd0);
      check("midrun reset out", {31'd0, out}, 32'd0);
      rst = 1'b1;
      run(32'd3, 32'd5, 1'b1);

      // Exhaustive N=4, back to back with i_valid held high.
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            a4       = 4'(x);
            b4       = 4'(y);
            i_valid4 = 1'b1;
            exp4_q.push_back($signed(a4) < $signed(b4));
            @(posedge clk);
            #1;
            guard = 0;
            while (!i_ready4 && guard < 50) begin
               @(posedge clk);
               #1;
               guard++;
            end
            if (guard >= 50) begin
               n_tests++;
               n_fail++;
               $display("FAIL n4 timeout: got i_ready4=0, expected 1 within 50 edges");
            end
         end
      end
      i_valid4 = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      check("n32 pending", exp_q.size(), 32'd0);
      check("n4 pending", exp4_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/slt_serial.md
SLT_SERIAL -- requirements
Module: slt_serial

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning operand width in bits (legal N >= 2).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port i_valid  input  1  operands a and b are valid.
REQ-005 The block SHALL have port i_ready  output  1  block can accept operands.
REQ-006 The block SHALL have port a  input  N  signed operand A, two's complement.
REQ-007 The block SHALL have port b  input  N  signed operand B, two's complement.
REQ-008 The block SHALL have port o_valid  output  1  result out is valid.
REQ-009 The block SHALL have port o_ready  input  1  consumer accepts result.
REQ-010 The block SHALL have port out  output  1  result, 1 iff signed a < b.

Function
REQ-011 Operation SHALL be a three-state FSM: S_IDLE, S_RUN, S_DONE.
REQ-012 i_ready SHALL equal 1 only in S_IDLE; o_valid SHALL equal 1 only in S_DONE.
REQ-013 In S_IDLE, an edge with i_valid=1 SHALL capture a and b into shift registers, clear the bit counter, set carry=1, and enter S_RUN; i_valid=0 SHALL leave it in S_IDLE.
REQ-014 In S_RUN, each edge SHALL process one bit, LSB first: sum = a_i XOR ~b_i XOR carry; carry <= majority(a_i, ~b_i, carry); shift both registers right by one; increment counter.
REQ-015 On the edge that processes bit N-1, the block SHALL register out = sum_msb XOR (carry_in_msb XOR carry_out_msb), i.e. sign XOR overflow of a-b, and enter S_DONE.
REQ-016 Latency SHALL be exactly N edges from the accepting edge to the first cycle with o_valid=1.
REQ-017 In S_DONE, out and o_valid SHALL hold stable while o_ready=0; an edge with o_ready=1 SHALL return to S_IDLE.
REQ-018 Input a, b and i_valid changes outside S_IDLE SHALL NOT affect the result in flight.
REQ-019 Throughput SHALL be one result per N+2 cycles minimum, with o_ready held at 1.
REQ-020 Counter width SHALL be $clog2(N); wrap-around SHALL never occur since the counter stops at N-1.
REQ-021 Equal operands SHALL give out=0; overflow cases such as most-negative vs. positive SHALL give the arithmetically correct signed result.

Reset
REQ-022 rst=0 at an edge SHALL force S_IDLE, i_ready=1, o_valid=0, out=0, counter=0, carry=0, and shift registers=0.
REQ-023 Reset during S_RUN or S_DONE SHALL discard the in-flight operation with no residual output.
REQ-024 Reset SHALL dominate i_valid and o_ready on the same edge.

Structure
REQ-025 The FSM state enum SHALL reside in the shared package slt_pkg, as type slt_state_t.
REQ-026 The per-bit adder SHALL be a separate sub-module, adder_1 (inputs a, b, c_in; outputs sum, c_out), instantiated once.
REQ-027 All sequential logic SHALL use always_ff; next-state and datapath logic SHALL use always_comb.

Verification
REQ-028 The bench SHALL cover the following directed scenarios, with N=32 unless stated otherwise:
- Post-reset cycle -> i_ready=1, o_valid=0, out=0.
- a=-1, b=1, o_ready=1 -> o_valid rises exactly 32 edges after accept, out=1, then i_ready=1 on the following cycle.
- a=32'h8000_0000, b=32'h7FFF_FFFF -> out=1; swapped operands -> out=0; a=b=0 -> out=0.
- a=32'h7FFF_FFFF, b=32'h8000_0000, o_ready=0 for 5 cycles -> o_valid and out=0 held stable for 5 cycles; a and b toggled meanwhile with no effect.
- rst=0 asserted at bit 10 of a run -> next cycle S_IDLE, o_valid=0, out=0; a fresh a=3, b=5 then gives out=1.
- N=4 exhaustive, all 256 pairs, back-to-back -> every out matches the behavioural signed a<b; error count 0.
